// File: rtl/load_store_unit_if.sv
`ifndef XLEN
`define XLEN 32
`endif
// Bundle between the core, the load/store unit and the word-wide data memory.
// Latency: none, wires only.
// Backpressure: o_ready gates acceptance of i_req; the requester holds i_req until accepted.
interface load_store_unit_if;
    // core -> unit
    logic              i_req;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [`XLEN-1:0]  i_addr;
    logic [`XLEN-1:0]  i_wdata;
    // unit -> core
    logic              o_ready;
    logic              o_done;
    logic              o_fault;
    logic [`XLEN-1:0]  o_rdata;
    // unit <-> data memory
    logic [`XLEN-1:0]  o_DM_Addr;
    logic [`XLEN-1:0]  o_DM_Wd;
    logic              o_DM_Wen;
    logic [`XLEN-1:0]  i_DM_Rd;

    // The load/store unit itself.
    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_DM_Rd,
        output o_ready, o_done, o_fault, o_rdata, o_DM_Addr, o_DM_Wd, o_DM_Wen
    );

    // The environment around it: core request side plus data memory.
    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_DM_Rd,
        input  o_ready, o_done, o_fault, o_rdata, o_DM_Addr, o_DM_Wd, o_DM_Wen
    );
endinterface

// File: rtl/load_store_unit.sv
`ifndef XLEN
`define XLEN 32
`endif
// RV32I load/store sequencer: word alignment, sub-word load extension, SB/SH read-modify-write.
// Latency: fault done at c+1, loads and SW at c+2, SB/SH at c+3 (c = accept cycle).
// Backpressure: o_ready only in IDLE; requests while busy are ignored, not queued.
module load_store_unit (
    input  logic             i_clk,
    input  logic             i_rst,
    load_store_unit_if.slave bus
);
    localparam int XLEN = `XLEN;

    typedef enum logic [2:0] {IDLE, RMW_RD, LOAD, WRITE, RESP, FAULT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wd_q;      // store data, replaced by the merged word for SB/SH
    logic [XLEN-1:0]   rdata_q;
    logic              illegal;
    logic              misaligned;
    logic              accept;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   merged;

    assign accept = (state_q == IDLE) && bus.i_req;

    // Classify the access presented on the request bus at accept time
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.i_we) begin
            illegal = bus.i_funct3[2] || (bus.i_funct3[1:0] == 2'b11);
        end else begin
            illegal = (bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11);
        end
        case (bus.i_funct3[1:0])
            2'b01:   misaligned = bus.i_addr[0];
            2'b10:   misaligned = (bus.i_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        bus.o_ready = 1'b0;
        bus.o_done  = 1'b0;
        bus.o_fault = 1'b0;
        case (state_q)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_req) begin
                    if (illegal || misaligned)          state_d = FAULT;
                    else if (!bus.i_we)                 state_d = LOAD;
                    else if (bus.i_funct3[1:0] == 2'b10) state_d = WRITE;
                    else                                state_d = RMW_RD;
                end
            end
            RMW_RD: state_d = WRITE;
            LOAD:   state_d = RESP;
            WRITE:  state_d = RESP;
            RESP: begin
                bus.o_done = 1'b1;
                state_d    = IDLE;
            end
            FAULT: begin
                bus.o_done  = 1'b1;
                bus.o_fault = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane selection and sign/zero extension of the word read from memory
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus.i_DM_Rd[7:0];
            2'd1:    rd_byte = bus.i_DM_Rd[15:8];
            2'd2:    rd_byte = bus.i_DM_Rd[23:16];
            default: rd_byte = bus.i_DM_Rd[31:24];
        endcase
        rd_half = lane_q[1] ? bus.i_DM_Rd[31:16] : bus.i_DM_Rd[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = bus.i_DM_Rd;
        endcase
    end

    // Merge the low byte/halfword of the store data into the old memory word
    always_comb begin
        merged = bus.i_DM_Rd;
        if (funct3_q[1:0] == 2'b00) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wd_q[7:0];
                2'd1:    merged[15:8]  = wd_q[7:0];
                2'd2:    merged[23:16] = wd_q[7:0];
                default: merged[31:24] = wd_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wd_q[15:0];
        end else begin
            merged[15:0]  = wd_q[15:0];
        end
    end

    // Request latch, load result and RMW word registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            funct3_q <= 3'd0;
            lane_q   <= 2'd0;
            addr_q   <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                funct3_q <= bus.i_funct3;
                lane_q   <= bus.i_addr[1:0];
                addr_q   <= {bus.i_addr[XLEN-1:2], 2'b00};
                wd_q     <= bus.i_wdata;
            end
            if (state_q == LOAD)   rdata_q <= load_ext;
            if (state_q == RMW_RD) wd_q    <= merged;
        end
    end

    assign bus.o_rdata   = rdata_q;
    assign bus.o_DM_Addr = addr_q;
    // Reset in the WRITE cycle suppresses the write.
    assign bus.o_DM_Wen  = (state_q == WRITE) && !i_rst;
    assign bus.o_DM_Wd   = (state_q == WRITE) ? wd_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, memory model, decoupled monitor.
// Latency: expected done/write cycles are pushed at accept and compared on DUT output.
// Backpressure: driver holds i_req until o_ready is seen, then moves on.
module tb_load_store_unit;
    logic i_clk = 1'b0;
    logic i_rst;
    load_store_unit_if bus ();

    load_store_unit dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Word-wide data memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    logic        pl_en  = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_dat = 32'd0;
    assign bus.i_DM_Rd = mem[bus.o_DM_Addr[7:2]];
    always @(posedge i_clk) begin
        if (pl_en)               mem[pl_idx] <= pl_dat;
        else if (bus.o_DM_Wen)   mem[bus.o_DM_Addr[7:2]] <= bus.o_DM_Wd;
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] fault; logic [31:0] rdata; string nm; } resp_t;
    typedef struct { int cyc; logic [31:0] addr;  logic [31:0] data;  string nm; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t mon_r;
    wr_t   mon_w;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    int          last_acc = -10;
    int          last_done = -1;
    logic [31:0] model_rdata = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pops.
    always @(negedge i_clk) begin
        if (mon_en && !i_rst) begin
            chk("o_ready", 32'(bus.o_ready),
                32'(!((cyc >= last_acc + 1) && (cyc <= last_done))));
            if (bus.o_done) begin
                if (resp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected o_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk({mon_r.nm, " done cycle"}, 32'(cyc), 32'(mon_r.cyc));
                    chk({mon_r.nm, " o_fault"}, 32'(bus.o_fault), mon_r.fault);
                    chk({mon_r.nm, " o_rdata"}, bus.o_rdata, mon_r.rdata);
                end
            end
            if (bus.o_DM_Wen) begin
                if (wr_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected o_DM_Wen: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk({mon_w.nm, " write cycle"}, 32'(cyc), 32'(mon_w.cyc));
                    chk({mon_w.nm, " o_DM_Addr"}, bus.o_DM_Addr, mon_w.addr);
                    chk({mon_w.nm, " o_DM_Wd"}, bus.o_DM_Wd, mon_w.data);
                end
            end else begin
                chk("o_DM_Wd idle", bus.o_DM_Wd, 32'd0);
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        pl_idx = idx[5:0];
        pl_dat = d;
        pl_en  = 1'b1;
        @(posedge i_clk); #1;
        pl_en  = 1'b0;
    endtask

    // Present one access and push its expected response. exp_val is the load
    // result for loads and the written word for stores. i_req stays high.
    task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic fault, input logic [31:0] exp_val);
        int    c;
        int    lat;
        bit    ok;
        resp_t r;
        wr_t   w;
        ok = 1'b0;
        bus.i_we     = we;
        bus.i_funct3 = f3;
        bus.i_addr   = addr;
        bus.i_wdata  = wdata;
        bus.i_req    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (bus.o_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk); #1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s accept timeout: got o_ready=0 expected 1", nm);
            bus.i_req = 1'b0;
        end else begin
            c   = cyc;
            lat = fault ? 1 : ((!we || f3 == 3'b010) ? 2 : 3);
            if (!fault && !we) model_rdata = exp_val;
            r.cyc = c + lat; r.fault = 32'(fault); r.rdata = model_rdata; r.nm = nm;
            resp_q.push_back(r);
            if (we && !fault) begin
                w.cyc = c + lat - 1; w.addr = {addr[31:2], 2'b00}; w.data = exp_val; w.nm = nm;
                wr_q.push_back(w);
            end
            last_acc  = c;
            last_done = c + lat;
            @(posedge i_clk); #1;
        end
    endtask

    task automatic drain();
        bus.i_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (resp_q.size() == 0 && wr_q.size() == 0) break;
            @(posedge i_clk); #1;
        end
        chk("drain response queue", 32'(resp_q.size()), 32'd0);
        chk("drain write queue", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a request pending: reset must win.
        i_rst        = 1'b1;
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b0;
        bus.i_funct3 = 3'b010;
        bus.i_addr   = 32'h10;
        bus.i_wdata  = 32'd0;
        @(posedge i_clk); #1;
        preload(4, 32'h80F17F01);
        preload(8, 32'h11223344);
        i_rst     = 1'b0;
        bus.i_req = 1'b0;
        @(negedge i_clk);
        chk("reset o_ready", 32'(bus.o_ready), 32'd1);
        chk("reset o_done", 32'(bus.o_done), 32'd0);
        chk("reset o_fault", 32'(bus.o_fault), 32'd0);
        chk("reset o_DM_Wen", 32'(bus.o_DM_Wen), 32'd0);
        chk("reset o_DM_Wd", bus.o_DM_Wd, 32'd0);
        chk("reset o_rdata", bus.o_rdata, 32'd0);
        chk("reset o_DM_Addr", bus.o_DM_Addr, 32'd0);
        mon_en = 1'b1;
        @(posedge i_clk); #1;

        // Mixed-width loads from 0x10 = 0x80F17F01
        issue("LB 0x13",  1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 32'hFFFFFF80);
        issue("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 32'h00000080);
        issue("LH 0x12",  1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 32'hFFFF80F1);
        issue("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'd0, 1'b0, 32'h00007F01);
        issue("LW 0x10",  1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h80F17F01);
        issue("LB 0x11",  1'b0, 3'b000, 32'h11, 32'd0, 1'b0, 32'h0000007F);
        issue("LBU 0x12", 1'b0, 3'b100, 32'h12, 32'd0, 1'b0, 32'h000000F1);
        issue("LH 0x10",  1'b0, 3'b001, 32'h10, 32'd0, 1'b0, 32'h00007F01);
        issue("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 32'h000080F1);
        drain();

        // Sub-word stores via read-modify-write on 0x20
        issue("SB 0x21", 1'b1, 3'b000, 32'h21, 32'hFFFFFFAB, 1'b0, 32'h1122AB44);
        drain();
        preload(8, 32'h11223344);
        issue("SH 0x22",    1'b1, 3'b001, 32'h22, 32'h1234BEEF, 1'b0, 32'hBEEF3344);
        issue("LW 0x20 a",  1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'hBEEF3344);
        issue("SB 0x23",    1'b1, 3'b000, 32'h23, 32'h000000CC, 1'b0, 32'hCCEF3344);
        issue("SB 0x20",    1'b1, 3'b000, 32'h20, 32'h0000005A, 1'b0, 32'hCCEF335A);
        issue("LW 0x20 b",  1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'hCCEF335A);
        issue("SH 0x20",    1'b1, 3'b001, 32'h20, 32'hFFFF7777, 1'b0, 32'hCCEF7777);
        issue("LW 0x20 c",  1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'hCCEF7777);
        // Full-word store
        issue("SW 0x30",    1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        issue("LW 0x30",    1'b0, 3'b010, 32'h30, 32'd0,        1'b0, 32'hDEADBEEF);
        drain();

        // Faults: misaligned and illegal funct3, no write, o_rdata held
        issue("LW 0x31 misaligned", 1'b0, 3'b010, 32'h31, 32'd0, 1'b1, 32'd0);
        issue("SH 0x23 misaligned", 1'b1, 3'b001, 32'h23, 32'hFFFF, 1'b1, 32'd0);
        issue("load f3 011",        1'b0, 3'b011, 32'h30, 32'd0, 1'b1, 32'd0);
        issue("store f3 011",       1'b1, 3'b011, 32'h30, 32'h5, 1'b1, 32'd0);
        issue("load f3 111",        1'b0, 3'b111, 32'h30, 32'd0, 1'b1, 32'd0);
        issue("LH 0x11 misaligned", 1'b0, 3'b001, 32'h11, 32'd0, 1'b1, 32'd0);
        drain();
        chk("mem 0x30 after faults", mem[12], 32'hDEADBEEF);

        // Continuous i_req with alternating SW/LW
        issue("SW 0x34 a", 1'b1, 3'b010, 32'h34, 32'h01020304, 1'b0, 32'h01020304);
        issue("LW 0x34 a", 1'b0, 3'b010, 32'h34, 32'd0,        1'b0, 32'h01020304);
        issue("SW 0x34 b", 1'b1, 3'b010, 32'h34, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5);
        issue("LW 0x34 b", 1'b0, 3'b010, 32'h34, 32'd0,        1'b0, 32'hA5A5A5A5);
        issue("SW 0x38",   1'b1, 3'b010, 32'h38, 32'h00000011, 1'b0, 32'h00000011);
        issue("LW 0x38",   1'b0, 3'b010, 32'h38, 32'd0,        1'b0, 32'h00000011);
        drain();

        // Reset during the WRITE cycle of an SB
        preload(8, 32'h11223344);
        issue("SB reset", 1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, 32'h1122AB44);
        bus.i_req = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        resp_q.delete();
        wr_q.delete();
        last_done   = -1;
        model_rdata = 32'd0;
        @(negedge i_clk);
        chk("o_DM_Wen under reset", 32'(bus.o_DM_Wen), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post-reset o_ready", 32'(bus.o_ready), 32'd1);
        chk("post-reset o_done", 32'(bus.o_done), 32'd0);
        chk("post-reset o_DM_Wd", bus.o_DM_Wd, 32'd0);
        chk("post-reset o_rdata", bus.o_rdata, 32'd0);
        chk("post-reset o_DM_Addr", bus.o_DM_Addr, 32'd0);
        chk("mem 0x20 after reset", mem[8], 32'h11223344);
        @(posedge i_clk); #1;
        issue("LW 0x20 after reset", 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 32'h11223344);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
